// File: rtl/bcd_updown_counter.sv
// Multi-digit BCD up/down counter stepped by rising edges of a slow divided tick.
// Supports synchronous clear, clamped parallel load, and a registered wrap pulse.
module bcd_updown_counter #(
    parameter int unsigned DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tick_in,
    input  logic                en,
    input  logic                up_dn,
    input  logic                clear,
    input  logic                load,
    input  logic [4*DIGITS-1:0] load_val,
    output logic [4*DIGITS-1:0] bcd,
    output logic                wrap,
    output logic                load_err
);

    logic                tick_q, tick_d;
    logic [4*DIGITS-1:0] bcd_q, bcd_d;
    logic                wrap_q, wrap_d;
    logic                load_err_q, load_err_d;

    logic                step;
    logic [4*DIGITS-1:0] stepped;
    logic                ripple_out;
    logic [4*DIGITS-1:0] clamped;
    logic                clamp_any;

    assign step = tick_in & ~tick_q & en;

    // Carry (up) or borrow (down) ripples through every digit in one cycle.
    always_comb begin
        logic       carry;
        logic [3:0] digit;
        stepped = bcd_q;
        carry   = 1'b1;
        for (int i = 0; i < int'(DIGITS); i++) begin
            digit = bcd_q[4*i +: 4];
            if (carry) begin
                if (up_dn) begin
                    if (digit == 4'd9) begin
                        stepped[4*i +: 4] = 4'd0;
                    end else begin
                        stepped[4*i +: 4] = digit + 4'd1;
                        carry             = 1'b0;
                    end
                end else begin
                    if (digit == 4'd0) begin
                        stepped[4*i +: 4] = 4'd9;
                    end else begin
                        stepped[4*i +: 4] = digit - 4'd1;
                        carry             = 1'b0;
                    end
                end
            end
        end
        ripple_out = carry;
    end

    always_comb begin
        clamped   = load_val;
        clamp_any = 1'b0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (load_val[4*i +: 4] > 4'd9) begin
                clamped[4*i +: 4] = 4'd9;
                clamp_any         = 1'b1;
            end
        end
    end

    always_comb begin
        tick_d     = tick_in;
        bcd_d      = bcd_q;
        wrap_d     = 1'b0;
        load_err_d = 1'b0;
        if (clear) begin
            bcd_d = '0;
        end else if (load) begin
            bcd_d      = clamped;
            load_err_d = clamp_any;
        end else if (step) begin
            bcd_d  = stepped;
            wrap_d = ripple_out;
        end
    end

    // tick_q resets high so a tick already high at release is not a step.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_q     <= 1'b1;
            bcd_q      <= '0;
            wrap_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            tick_q     <= tick_d;
            bcd_q      <= bcd_d;
            wrap_q     <= wrap_d;
            load_err_q <= load_err_d;
        end
    end

    assign bcd      = bcd_q;
    assign wrap     = wrap_q;
    assign load_err = load_err_q;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Bench for bcd_updown_counter: vector table, corner sequences, and random run
// against an integer-arithmetic reference model.
module tb_bcd_updown_counter;

    localparam int DIGITS = 4;
    localparam int MAXV   = 10000;

    logic        clk = 1'b0;
    logic        rst;
    logic        tick_in, en, up_dn, clear, load;
    logic [15:0] load_val;
    logic [15:0] bcd;
    logic        wrap, load_err;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state
    int m_cnt;
    bit m_tick;
    bit m_wrap;
    bit m_err;

    typedef struct {
        bit          t, e, u, c, l;
        logic [15:0] lv;
        logic [15:0] eb;
        bit          ew, ee;
    } vec_t;

    vec_t tbl[$];

    bcd_updown_counter #(.DIGITS(DIGITS)) dut (
        .clk      (clk),
        .rst      (rst),
        .tick_in  (tick_in),
        .en       (en),
        .up_dn    (up_dn),
        .clear    (clear),
        .load     (load),
        .load_val (load_val),
        .bcd      (bcd),
        .wrap     (wrap),
        .load_err (load_err)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] int2bcd(input int v);
        logic [15:0] r;
        int x = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic int load_value(input logic [15:0] v, output bit err);
        int s = 0;
        int d;
        err = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            d = int'(v[4*i +: 4]);
            if (d > 9) begin
                d   = 9;
                err = 1'b1;
            end
            s = s * 10 + d;
        end
        return s;
    endfunction

    function automatic vec_t mk(input bit t, e, u, c, l, input logic [15:0] lv,
                                input logic [15:0] eb, input bit ew, ee);
        vec_t v;
        v.t = t; v.e = e; v.u = u; v.c = c; v.l = l;
        v.lv = lv; v.eb = eb; v.ew = ew; v.ee = ee;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_cnt  = 0;
        m_tick = 1'b1;
        m_wrap = 1'b0;
        m_err  = 1'b0;
    endtask

    // Drive one cycle of inputs, advance the model, and return #1 after the edge.
    task automatic apply(input bit t, e, u, c, l, input logic [15:0] lv);
        bit st;
        bit er;
        int v;
        tick_in  = t;
        en       = e;
        up_dn    = u;
        clear    = c;
        load     = l;
        load_val = lv;
        st       = t && !m_tick && e;
        m_wrap   = 1'b0;
        m_err    = 1'b0;
        if (c) begin
            m_cnt = 0;
        end else if (l) begin
            v     = load_value(lv, er);
            m_cnt = v;
            m_err = er;
        end else if (st) begin
            if (u) begin
                m_wrap = (m_cnt == MAXV - 1);
                m_cnt  = (m_cnt + 1) % MAXV;
            end else begin
                m_wrap = (m_cnt == 0);
                m_cnt  = (m_cnt + MAXV - 1) % MAXV;
            end
        end
        m_tick = t;
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        check({tag, ".bcd"}, 32'(bcd), 32'(int2bcd(m_cnt)));
        check({tag, ".wrap"}, 32'(wrap), 32'(m_wrap));
        check({tag, ".load_err"}, 32'(load_err), 32'(m_err));
    endtask

    initial begin
        rst = 1'b0; tick_in = 1'b1; en = 1'b1; up_dn = 1'b1;
        clear = 1'b0; load = 1'b0; load_val = '0;
        model_reset();

        // Startup: tick already high at release must not step
        repeat (3) @(posedge clk);
        #1;
        check("reset.bcd", 32'(bcd), 32'h0);
        check("reset.wrap", 32'(wrap), 32'h0);
        check("reset.load_err", 32'(load_err), 32'h0);
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            apply(1, 1, 1, 0, 0, 16'h0);
            check("startup.bcd", 32'(bcd), 32'h0);
            check("startup.wrap", 32'(wrap), 32'h0);
        end

        tbl.push_back(mk(0, 1, 1, 0, 1, 16'h0199, 16'h0199, 0, 0));
        tbl.push_back(mk(1, 1, 1, 0, 0, 16'h0000, 16'h0200, 0, 0));
        tbl.push_back(mk(1, 1, 1, 0, 0, 16'h0000, 16'h0200, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 16'h0000, 16'h0200, 0, 0));
        tbl.push_back(mk(1, 1, 1, 0, 1, 16'h9999, 16'h9999, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 16'h0000, 16'h9999, 0, 0));
        tbl.push_back(mk(1, 1, 1, 0, 0, 16'h0000, 16'h0000, 1, 0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 16'h0000, 16'h0000, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 0, 16'h0000, 16'h9999, 1, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 16'h0000, 16'h9999, 0, 0));
        tbl.push_back(mk(1, 1, 1, 1, 1, 16'h1234, 16'h0000, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 1, 16'h1A3F, 16'h1939, 0, 1));
        tbl.push_back(mk(0, 1, 1, 0, 0, 16'h0000, 16'h1939, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 1, 16'h1234, 16'h1234, 0, 0));
        tbl.push_back(mk(1, 0, 1, 0, 0, 16'h0000, 16'h1234, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 16'h0000, 16'h1234, 0, 0));
        tbl.push_back(mk(1, 0, 1, 0, 0, 16'h0000, 16'h1234, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 16'h0000, 16'h1234, 0, 0));
        tbl.push_back(mk(1, 0, 1, 0, 0, 16'h0000, 16'h1234, 0, 0));
        tbl.push_back(mk(1, 1, 1, 0, 0, 16'h0000, 16'h1234, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 16'h0000, 16'h1234, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 0, 16'h0000, 16'h1233, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 1, 16'h1000, 16'h1000, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 0, 16'h0000, 16'h0999, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 16'h0000, 16'h0999, 0, 0));
        tbl.push_back(mk(1, 1, 1, 0, 0, 16'h0000, 16'h1000, 0, 0));

        foreach (tbl[i]) begin
            apply(tbl[i].t, tbl[i].e, tbl[i].u, tbl[i].c, tbl[i].l, tbl[i].lv);
            check($sformatf("vec%0d.bcd", i), 32'(bcd), 32'(tbl[i].eb));
            check($sformatf("vec%0d.wrap", i), 32'(wrap), 32'(tbl[i].ew));
            check($sformatf("vec%0d.load_err", i), 32'(load_err), 32'(tbl[i].ee));
        end

        // Carry run: 0199 -> 0200 -> ten more edges -> 0210
        apply(0, 1, 1, 0, 1, 16'h0199);
        apply(1, 1, 1, 0, 0, 16'h0);
        check("carry.first", 32'(bcd), 32'h0200);
        for (int i = 0; i < 10; i++) begin
            apply(0, 1, 1, 0, 0, 16'h0);
            apply(1, 1, 1, 0, 0, 16'h0);
        end
        check("carry.ten", 32'(bcd), 32'h0210);

        // Asynchronous reset between edges
        apply(0, 1, 1, 0, 1, 16'h0457);
        check("async.pre", 32'(bcd), 32'h0457);
        #3;
        rst = 1'b0;
        #1;
        check("async.bcd", 32'(bcd), 32'h0);
        check("async.wrap", 32'(wrap), 32'h0);
        model_reset();
        #2;
        rst = 1'b1;
        apply(0, 1, 1, 0, 0, 16'h0);
        check("async.hold", 32'(bcd), 32'h0);
        apply(1, 1, 1, 0, 0, 16'h0);
        check("async.resume", 32'(bcd), 32'h0001);

        // Random run against the reference model
        for (int i = 0; i < 800; i++) begin
            bit          t, e, u, c, l;
            logic [15:0] lv;
            int          sel;
            t   = 1'($urandom_range(0, 1));
            e   = ($urandom_range(0, 7) != 0);
            u   = 1'($urandom_range(0, 1));
            c   = ($urandom_range(0, 59) == 0);
            l   = ($urandom_range(0, 19) == 0);
            sel = $urandom_range(0, 3);
            lv  = (sel == 0) ? 16'h9998 : (sel == 1) ? 16'h0001 : 16'($urandom);
            apply(t, e, u, c, l, lv);
            check_model($sformatf("rand%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
